// File: rtl/serial_lookahead_subtractor.sv
// serial_lookahead_subtractor
// Nibble-serial subtractor that computes a - b - borrow_in as a + ~b + ~borrow_in.
// It handles one 4-bit nibble per clock, LSB nibble first. Each nibble uses a full
// carry-lookahead adder, and the nibble carry-out is registered for the next nibble.
// Handshake: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Optional feature: define SUB_OVERFLOW_FLAG_EN to add the signed overflow output.
module serial_lookahead_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lookahead carries c[0..4] for x + y + cin. Every carry is a flat sum of
    // products over the generate and propagate terms, so no carry ripples from bit to bit.
    function automatic logic [4:0] cla_carries(input logic [3:0] x, input logic [3:0] y,
                                               input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;
    logic [3:0]       a_nib_s;
    logic [3:0]       nb_nib_s;
    logic [4:0]       carry_s;
    logic [3:0]       sum_s;
    logic [WIDTH-1:0] result_s;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             overflow_r;
`endif

    // Select the current nibble and compute its sum with the registered carry.
    always_comb begin
        a_nib_s  = a_r[{k_r, 2'b00} +: 4];
        nb_nib_s = ~b_r[{k_r, 2'b00} +: 4];
        carry_s  = cla_carries(a_nib_s, nb_nib_s, carry_r);
        sum_s    = (a_nib_s ^ nb_nib_s) ^ carry_s[3:0];
        result_s = acc_r;
        result_s[{k_r, 2'b00} +: 4] = sum_s;
    end

    // Next-state logic. Leaving DONE returns to IDLE without accepting new operands on that edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (k_r == K_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs, which follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Datapath: capture operands, accumulate nibbles, and publish the result only when entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r          <= '0;
            b_r          <= '0;
            acc_r        <= '0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
            carry_r      <= 1'b0;
            k_r          <= '0;
`ifdef SUB_OVERFLOW_FLAG_EN
            overflow_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= ~borrow_in;
                        k_r     <= '0;
                        acc_r   <= '0;
                    end
                end
                BUSY: begin
                    acc_r   <= result_s;
                    carry_r <= carry_s[4];
                    k_r     <= k_r + KW'(1);
                    if (k_r == K_LAST) begin
                        diff_r       <= result_s;
                        borrow_out_r <= ~carry_s[4];
`ifdef SUB_OVERFLOW_FLAG_EN
                        overflow_r   <= carry_s[4] ^ carry_s[3];
`endif
                    end
                end
                default: begin
                    k_r <= k_r;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;
`ifdef SUB_OVERFLOW_FLAG_EN
    assign overflow   = overflow_r;
`endif

endmodule

// File: doc/serial_lookahead_subtractor.md
SERIAL_LOOKAHEAD_SUBTRACTOR -- requirements
Module: serial_lookahead_subtractor

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operands and borrow_in presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 borrow_in  input  1  borrow into the LSB.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  difference.
REQ-012 borrow_out  output  1  borrow out of the MSB.
REQ-013 overflow  output  1  signed overflow; present only when SUB_OVERFLOW_FLAG_EN is defined.

Function
REQ-014 Arithmetic: diff = (a - b - borrow_in) mod 2^WIDTH; borrow_out = 1 iff unsigned a < b + borrow_in.
REQ-015 Computation SHALL be performed as a + ~b + ~borrow_in, one 4-bit nibble per cycle, LSB nibble first.
  - Within a nibble, carries SHALL use full 4-bit lookahead: per-bit propagate p = a^~b and generate g = a&~b, with no ripple between bits.
  - The nibble carry-out SHALL be registered and fed to the next nibble.
REQ-016 States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: processing nibble index k from 0 to N-1, where N = WIDTH/4.
  - DONE: out_valid=1.
REQ-017 Transition IDLE->BUSY on a rising edge with in_valid=1 and in_ready=1.
  - a, b and borrow_in SHALL be captured at that edge.
  - The nibble index SHALL be cleared to 0.
  - Inputs SHALL be ignored after capture.
REQ-018 BUSY: one nibble completes per cycle. BUSY->DONE at the edge completing nibble N-1.
  - out_valid SHALL rise exactly N cycles after the acceptance edge.
REQ-019 DONE: diff, borrow_out (and overflow) SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 DONE->IDLE on a rising edge with out_valid=1 and out_ready=1.
  - in_ready SHALL be 1 in the following cycle.
  - No new operands SHALL be accepted in that same edge.
REQ-021 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states has no effect.
REQ-022 borrow_out SHALL equal the inverse of the final nibble carry-out.
REQ-023 diff SHALL update only when entering DONE; partial nibbles are not visible on diff before out_valid.
REQ-024 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, independent of clk.
  - Reset values: in_ready=1, out_valid=0, diff=0, borrow_out=0, overflow=0.
  - The nibble index and carry register SHALL clear.
REQ-026 Assertion of rst in BUSY or DONE SHALL discard the operation; no result is produced.
REQ-027 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Configuration
REQ-028 Macro SUB_OVERFLOW_FLAG_EN.
  - Defined: overflow port exists; it equals carry-into-MSB XOR carry-out-of-MSB of the final nibble, i.e. 1 iff the signed result of a - b - borrow_in lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; it is updated and held with diff.
  - Undefined: the overflow port and its logic are absent; all other behaviour is identical.

Verification (WIDTH=16, N=4)
REQ-029 a=0x1234, b=0x0234, borrow_in=0 -> out_valid 4 cycles after acceptance; diff=0x1000, borrow_out=0.
REQ-030 a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1; overflow=0 (macro defined).
REQ-031 a=0x8000, b=0x7FFF, borrow_in=1 -> diff=0x0000, borrow_out=0; overflow=1 (macro defined).
REQ-032 Hold out_ready=0 for 10 cycles after out_valid with in_valid=1 and new operands -> diff is stable, in_ready=0, and the new operands are not captured; one cycle after out_ready=1, in_ready=1.
REQ-033 Assert rst asynchronously in BUSY at k=2 -> same-cycle in_ready=1, out_valid=0, diff=0; the next operation 0x0005-0x0003 yields diff=0x0002, borrow_out=0.
REQ-034 Back-to-back: out_ready tied to 1, in_valid tied to 1 -> one result every N+2 cycles; each result matches the reference arithmetic over 1000 random vectors.
